axis_write_fifo: RTL

Buffers the AXI4-Stream words produced by the AXI4-Lite-to-stream writer and re-issues them on a fully handshaked AXI4-Stream master. The writer cannot be stalled, so this block absorbs bursts of register writes, never backpressures its input, and counts any words it has to drop. It sits between the processor-facing register writer and downstream stream consumers such as DDS and DAC control, or a serialiser.

---
 rtl/axis_write_fifo.sv | 96 +++++++++
 1 files changed

// File: rtl/axis_write_fifo.sv
// axis_write_fifo
//   Absorbs words from a producer that cannot be stalled (no s_axis_tready)
//   and re-issues them on a fully handshaked AXI4-Stream master. When the
//   buffer is full and nothing drains in the same cycle, the incoming word
//   is dropped, a sticky overflow flag is set and a saturating drop counter
//   increments.
//
// Ports
//   aclk            rising-edge clock
//   areset          synchronous, active-high reset
//   s_axis_tdata    input word
//   s_axis_tvalid   input word valid (one word per valid cycle)
//   m_axis_tdata    head-of-FIFO word
//   m_axis_tvalid   FIFO not empty
//   m_axis_tready   downstream accepts head word
//   fifo_count      stored words, 0..2^FIFO_ADDR_WIDTH
//   overflow        sticky: a word was dropped
//   drop_count      dropped words, saturating at 16'hFFFF
//   overflow_clear  clears overflow and drop_count (a same-cycle drop wins)
module axis_write_fifo #(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [FIFO_ADDR_WIDTH:0]  fifo_count,
    output logic                      overflow,
    output logic [15:0]               drop_count,
    input  logic                      overflow_clear
);

    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam int AW    = FIFO_ADDR_WIDTH;

    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]               wr_ptr;
    logic [AW:0]               rd_ptr;

    logic empty;
    logic full;
    logic rd;
    logic wr;
    logic drop;

    // Pointers carry one extra MSB so full and empty stay distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign rd   = m_axis_tvalid & m_axis_tready;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr   = s_axis_tvalid & (~full | rd);
    assign drop = s_axis_tvalid & full & ~rd;

    assign m_axis_tvalid = ~empty;
    assign m_axis_tdata  = mem[rd_ptr[AW-1:0]];
    assign fifo_count    = wr_ptr - rd_ptr;

    // Storage has no reset; contents are only observable behind valid pointers.
    always_ff @(posedge aclk) begin
        if (wr && !areset)
            mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // A drop coinciding with a clear counts as the first drop after the clear.
    always_ff @(posedge aclk) begin
        if (areset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (overflow_clear)
                drop_count <= 16'd1;
            else if (drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end else if (overflow_clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule
